i2s_mic_rx: RTL and testbench

I2S receive front end for the microphone path. It takes the raw audio pins (`aud_bclk`, `aud_adclrck`, `gpio_din1`), synchronises them into the fabric clock and deserialises each left/right slot into a sign-extended 32-bit sample. Samples are buffered in a small FIFO and presented on a valid/ready stream. That stream directly feeds `mic_system`, which produces `codec_stream`.

---
 rtl/i2s_mic_pkg.sv | 26 ++
 rtl/i2s_sample_fifo.sv | 74 +++++++
 rtl/i2s_mic_rx.sv | 194 +++++++++++++++++++
 tb/tb_i2s_mic_rx.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_mic_pkg.sv
// Shared types and constants for the I2S microphone receive path.
package i2s_mic_pkg;

  localparam int SAMPLE_W = 32;
  localparam int ERRCNT_W = 8;

  // Bit positions of the raw audio pins inside the synchroniser vector.
  localparam int PIN_BCLK = 0;
  localparam int PIN_LRCK = 1;
  localparam int PIN_DIN  = 2;
  localparam int PIN_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_SHIFT,
    ST_WAIT
  } state_t;

  // One FIFO entry: slot identifier plus the sign-extended sample.
  typedef struct packed {
    logic                chan;
    logic [SAMPLE_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/i2s_sample_fifo.sv
// Synchronous sample FIFO with a registered head-of-queue output.
// Capacity is exactly DEPTH; the output register mirrors the oldest entry.
module i2s_sample_fifo
  import i2s_mic_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  fifo_entry_t wr_data,
  output logic        wr_accept,
  input  logic        rd_ready,
  output logic        rd_valid,
  output fifo_entry_t rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        valid_q, valid_d;
  fifo_entry_t head_q, head_d;
  fifo_entry_t mem_q [DEPTH];
  logic        full;
  logic        do_push;
  logic        do_pop;

  // Pointer arithmetic and next head-of-queue selection.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
               (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_pop   = valid_q && rd_ready;
    do_push  = wr_en && (!full || do_pop);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_push);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_pop);
    valid_d  = (wr_ptr_d != rd_ptr_d);
    head_d   = mem_q[rd_ptr_d[AW-1:0]];
    // A write landing on the slot that becomes the head bypasses the array.
    if (do_push && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wr_data;
    end
  end

  // Storage array write port.
  // NOTE: the data array is not reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  // Pointer and output registers.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  assign wr_accept = do_push;
  assign rd_valid  = valid_q;
  assign rd_data   = head_q;

endmodule

// File: rtl/i2s_mic_rx.sv
// I2S microphone receiver: pin synchronisation, slot deserialisation,
// sample FIFO and valid/ready output stream.
module i2s_mic_rx
  import i2s_mic_pkg::*;
#(
  parameter int DATA_W      = 24,
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic                aud_bclk,
  input  logic                aud_adclrck,
  input  logic                gpio_din1,
  output logic [SAMPLE_W-1:0] st_data,
  output logic                st_channel,
  output logic                st_valid,
  input  logic                st_ready,
  input  logic                clear_i,
  output logic                overflow,
  output logic [ERRCNT_W-1:0] frame_err_cnt
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic [PIN_W-1:0] pins_raw;
  logic [PIN_W-1:0] pins_s;

  assign pins_raw = {gpio_din1, aud_adclrck, aud_bclk};

  // Per-pin flip-flop synchroniser chain.
  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    logic [PIN_W-1:0] stage_q;
    if (g == 0) begin : g_first
      // First stage samples the asynchronous pins.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) stage_q <= '0;
        else                stage_q <= pins_raw;
      end
    end else begin : g_next
      // Later stages resolve metastability.
      always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) stage_q <= '0;
        else                stage_q <= g_sync[g-1].stage_q;
      end
    end
  end

  assign pins_s = g_sync[SYNC_STAGES-1].stage_q;

  logic                bclk_prev_q, bclk_prev_d;
  logic                lr_last_q, lr_last_d;
  logic                primed_q, primed_d;
  logic                bclk_rise;
  logic                lr_edge;
  state_t              state_q, state_d;
  logic                chan_q, chan_d;
  logic [CNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [DATA_W-1:0]   shreg_shift;
  logic                overflow_q, overflow_d;
  logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                push;
  logic                frame_err;
  logic                push_accept;
  fifo_entry_t         push_entry;
  fifo_entry_t         pop_entry;

  // Edge detection: BCLK rise, and LRCK level changes seen on a BCLK rise.
  // primed_q suppresses a false LRCK edge against the reset value of lr_last_q.
  always_comb begin
    bclk_rise   = pins_s[PIN_BCLK] && !bclk_prev_q;
    lr_edge     = bclk_rise && primed_q && (pins_s[PIN_LRCK] != lr_last_q);
    bclk_prev_d = pins_s[PIN_BCLK];
    lr_last_d   = bclk_rise ? pins_s[PIN_LRCK] : lr_last_q;
    primed_d    = primed_q || bclk_rise;
  end

  // Slot framing FSM: next state, shift register and push request.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    bitcnt_d    = bitcnt_q;
    shreg_d     = shreg_q;
    push        = 1'b0;
    frame_err   = 1'b0;
    shreg_shift = {shreg_q[DATA_W-2:0], pins_s[PIN_DIN]};
    unique case (state_q)
      ST_IDLE: begin
        if (lr_edge) begin
          chan_d  = pins_s[PIN_LRCK];
          state_d = ST_DELAY;
        end
      end
      ST_DELAY: begin
        if (lr_edge) begin
          chan_d = pins_s[PIN_LRCK];
        end else if (bclk_rise) begin
          bitcnt_d = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bclk_rise) begin
          if (bitcnt_q == LAST_BIT) begin
            // Last bit wins over a coincident LRCK edge; the new slot still starts.
            shreg_d = shreg_shift;
            push    = 1'b1;
            if (lr_edge) begin
              chan_d  = pins_s[PIN_LRCK];
              state_d = ST_DELAY;
            end else begin
              state_d = ST_WAIT;
            end
          end else if (lr_edge) begin
            frame_err = 1'b1;
            chan_d    = pins_s[PIN_LRCK];
            state_d   = ST_DELAY;
          end else begin
            shreg_d  = shreg_shift;
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (lr_edge) begin
          chan_d  = pins_s[PIN_LRCK];
          state_d = ST_DELAY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sticky overflow and saturating short-slot counter; clear has priority.
  always_comb begin
    push_entry.chan = chan_q;
    push_entry.data = SAMPLE_W'($signed(shreg_shift));
    overflow_d      = overflow_q || (push && !push_accept);
    err_cnt_d       = err_cnt_q;
    if (frame_err && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
    if (clear_i) begin
      overflow_d = 1'b0;
      err_cnt_d  = '0;
    end
  end

  // Framing, edge-detect and status registers.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_prev_q <= 1'b0;
      lr_last_q   <= 1'b0;
      primed_q    <= 1'b0;
      state_q     <= ST_IDLE;
      chan_q      <= 1'b0;
      bitcnt_q    <= '0;
      shreg_q     <= '0;
      overflow_q  <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      bclk_prev_q <= bclk_prev_d;
      lr_last_q   <= lr_last_d;
      primed_q    <= primed_d;
      state_q     <= state_d;
      chan_q      <= chan_d;
      bitcnt_q    <= bitcnt_d;
      shreg_q     <= shreg_d;
      overflow_q  <= overflow_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  i2s_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .wr_en     (push),
    .wr_data   (push_entry),
    .wr_accept (push_accept),
    .rd_ready  (st_ready),
    .rd_valid  (st_valid),
    .rd_data   (pop_entry)
  );

  assign st_data       = pop_entry.data;
  assign st_channel    = pop_entry.chan;
  assign overflow      = overflow_q;
  assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_i2s_mic_rx.sv
// Scoreboard bench: two receivers (24-bit and 32-bit slots) driven by
// directed I2S frames; monitors pop expected samples on each transfer.
module tb_i2s_mic_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        bclk_a, lr_a, din_a, rdy_a, clr_a;
  logic        bclk_b, lr_b, din_b, rdy_b, clr_b;
  logic [31:0] data_a, data_b;
  logic        chan_a, chan_b, valid_a, valid_b, ovf_a, ovf_b;
  logic [7:0]  errcnt_a, errcnt_b;

  int n_vec = 0;
  int n_err = 0;
  logic [32:0] q_a[$];
  logic [32:0] q_b[$];

  localparam logic [31:0] OVF_RAW [10] = '{
    32'h000001, 32'h800000, 32'h123456, 32'hABCDEF, 32'h7FFFFF,
    32'hFFFFFF, 32'h400000, 32'hC00001, 32'h0F0F0F, 32'hF0F0F0};
  localparam logic [31:0] OVF_EXP [10] = '{
    32'h00000001, 32'hFF800000, 32'h00123456, 32'hFFABCDEF, 32'h007FFFFF,
    32'hFFFFFFFF, 32'h00400000, 32'hFFC00001, 32'h000F0F0F, 32'hFFF0F0F0};

  i2s_mic_rx #(.DATA_W(24), .FIFO_DEPTH(8), .SYNC_STAGES(2)) dut_a (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .aud_bclk(bclk_a), .aud_adclrck(lr_a), .gpio_din1(din_a),
    .st_data(data_a), .st_channel(chan_a), .st_valid(valid_a), .st_ready(rdy_a),
    .clear_i(clr_a), .overflow(ovf_a), .frame_err_cnt(errcnt_a));

  i2s_mic_rx #(.DATA_W(32), .FIFO_DEPTH(8), .SYNC_STAGES(2)) dut_b (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .aud_bclk(bclk_b), .aud_adclrck(lr_b), .gpio_din1(din_b),
    .st_data(data_b), .st_channel(chan_b), .st_valid(valid_b), .st_ready(rdy_b),
    .clear_i(clr_b), .overflow(ovf_b), .frame_err_cnt(errcnt_b));

  task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: compare every accepted sample against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && valid_a && rdy_a) begin
      if (q_a.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mon_a: unexpected sample %h", {chan_a, data_a});
      end else begin
        check("mon_a", {chan_a, data_a}, q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && valid_b && rdy_b) begin
      if (q_b.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL mon_b: unexpected sample %h", {chan_b, data_b});
      end else begin
        check("mon_b", {chan_b, data_b}, q_b.pop_front());
      end
    end
  end

  // One BCLK period (16 fabric clocks): data and LRCK change while BCLK is low.
  // pop_here opens st_ready for exactly the clock on which this bit's push lands.
  task automatic send_bit(input bit sel, input logic lr, input logic d, input bit pop_here);
    if (!sel) begin bclk_a = 1'b0; lr_a = lr; din_a = d; end
    else      begin bclk_b = 1'b0; lr_b = lr; din_b = d; end
    #80;
    if (!sel) bclk_a = 1'b1;
    else      bclk_b = 1'b1;
    if (pop_here) begin
      fork
        begin
          @(posedge clk);
          @(posedge clk);
          #1 rdy_a = 1'b1;
          @(posedge clk);
          #1 rdy_a = 1'b0;
        end
      join_none
    end
    #80;
  endtask

  // One LRCK slot of len BCLKs: bit 0 = first_din (previous word's tail),
  // bit 1 = I2S delay bit, bits 2.. = raw MSB first.
  task automatic send_slot(input bit sel, input logic lr, input logic [31:0] raw,
                           input int len, input int dw, input logic first_din,
                           input bit pop_last);
    for (int j = 0; j < len; j++) begin
      logic d;
      d = 1'b0;
      if (j == 0) d = first_din;
      else if (j >= 2 && j < 2 + dw) d = raw[dw - 1 - (j - 2)];
      send_bit(sel, lr, d, pop_last && (j == dw + 1));
    end
  endtask

  task automatic drain(input string name);
    int i;
    i = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && i < 4000) begin
      @(posedge clk);
      i++;
    end
    #1;
    check(name, 33'(q_a.size() + q_b.size()), 33'd0);
  endtask

  task automatic pulse_clear_a();
    clr_a = 1'b1;
    @(posedge clk);
    #1 clr_a = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    bclk_a = 1'b0; lr_a = 1'b0; din_a = 1'b0; rdy_a = 1'b1; clr_a = 1'b0;
    bclk_b = 1'b0; lr_b = 1'b0; din_b = 1'b0; rdy_b = 1'b1; clr_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_a", valid_a, 0);
    check("rst_sample_a", {chan_a, data_a}, 0);
    check("rst_ovf_a", ovf_a, 0);
    check("rst_errcnt_a", errcnt_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_sample_b", {chan_b, data_b}, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 32-bit slots: LRCK edge on the last data bit.
    send_slot(1'b1, 1'b1, 32'h0, 36, 32, 1'b0, 1'b0);
    q_b.push_back({1'b0, 32'h80000001});
    send_slot(1'b1, 1'b0, 32'h80000001, 33, 32, 1'b0, 1'b0);
    q_b.push_back({1'b1, 32'h12345678});
    send_slot(1'b1, 1'b1, 32'h12345678, 34, 32, 1'b1, 1'b0);
    drain("edge_order_drain");
    check("edge_order_errcnt", errcnt_b, 0);

    // Nominal 24-bit left/right pair after a priming slot.
    send_slot(1'b0, 1'b1, 32'h0, 32, 24, 1'b0, 1'b0);
    q_a.push_back({1'b0, 32'h007FFFFF});
    send_slot(1'b0, 1'b0, 32'h7FFFFF, 32, 24, 1'b0, 1'b0);
    q_a.push_back({1'b1, 32'hFF800001});
    send_slot(1'b0, 1'b1, 32'h800001, 32, 24, 1'b0, 1'b0);

    // Short slot, then clear.
    send_slot(1'b0, 1'b0, 32'h0, 10, 24, 1'b0, 1'b0);
    q_a.push_back({1'b1, 32'h00123456});
    send_slot(1'b0, 1'b1, 32'h123456, 32, 24, 1'b0, 1'b0);
    check("short_errcnt", errcnt_a, 1);
    pulse_clear_a();
    check("clear_errcnt", errcnt_a, 0);

    send_slot(1'b0, 1'b0, 32'h0, 10, 24, 1'b0, 1'b0);
    q_a.push_back({1'b1, 32'hFFABCDEF});
    send_slot(1'b0, 1'b1, 32'hABCDEF, 32, 24, 1'b0, 1'b0);
    check("short2_errcnt", errcnt_a, 1);
    drain("short_drain");

    // Reset asserted mid-slot; the partial slot must never be emitted.
    send_slot(1'b0, 1'b0, 32'hFFFFFF, 12, 24, 1'b0, 1'b0);
    rst_n = 1'b0;
    #20;
    check("midrst_valid", valid_a, 0);
    check("midrst_errcnt", errcnt_a, 0);
    rst_n = 1'b1;
    send_slot(1'b0, 1'b0, 32'h0, 20, 24, 1'b0, 1'b0);
    q_a.push_back({1'b1, 32'h00000001});
    send_slot(1'b0, 1'b1, 32'h000001, 32, 24, 1'b0, 1'b0);
    q_a.push_back({1'b0, 32'hFF800000});
    send_slot(1'b0, 1'b0, 32'h800000, 32, 24, 1'b0, 1'b0);
    drain("realign_drain");

    // Overflow: 10 slots into an 8-deep FIFO with the consumer stalled.
    rdy_a = 1'b0;
    for (int k = 0; k < 10; k++) begin
      logic lr_k;
      lr_k = (k % 2 == 0);
      if (k < 8) q_a.push_back({lr_k, OVF_EXP[k]});
      send_slot(1'b0, lr_k, OVF_RAW[k], 32, 24, 1'b0, 1'b0);
      if (k == 7) begin
        check("ovf_at_full", ovf_a, 0);
        check("stall_valid", valid_a, 1);
        check("stall_head", {chan_a, data_a}, {1'b1, OVF_EXP[0]});
      end
    end
    check("ovf_set", ovf_a, 1);
    check("stall_hold", {chan_a, data_a}, {1'b1, OVF_EXP[0]});
    rdy_a = 1'b1;
    drain("ovf_drain");
    pulse_clear_a();
    check("ovf_clear", ovf_a, 0);

    // Full FIFO receives a push on the same clock as a pop.
    rdy_a = 1'b0;
    for (int k = 0; k < 9; k++) begin
      logic lr_k;
      lr_k = (k % 2 == 0);
      q_a.push_back({lr_k, OVF_EXP[k]});
      send_slot(1'b0, lr_k, OVF_RAW[k], 32, 24, 1'b0, k == 8);
    end
    check("full_pop_ovf", ovf_a, 0);
    rdy_a = 1'b1;
    drain("full_pop_drain");
    check("full_pop_ovf_end", ovf_a, 0);
    check("final_errcnt", errcnt_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
